// File: rtl/led7_pkg.sv
// led7_scan shared definitions
// digit-register bit positions, hex glyph table, scan states
package led7_pkg;

  localparam int HEX_B = 8;
  localparam int EN_B  = 9;

  // glyph[n] is the gfedcba pattern for hex digit n
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } scan_t;

  // slot counter width for a given DIV
  function automatic int cnt_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/led7_scan_hex7seg.sv
// hex7seg: 4-bit nibble to gfedcba segment decode
// purely combinational, active-high segments
module hex7seg
  import led7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = GLYPHS[i_nib];

endmodule

// File: rtl/led7_scan.sv
// led7_scan: Wishbone slave driving a 4-digit 7-seg display
// four digit registers, hardware scan with blanking gap
module led7_scan
  import led7_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic        CLK_I,
  input  logic        RES_I,
  input  logic [1:0]  ADR_I,
  input  logic        WE_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic [1:0]  SEL_I,
  input  logic [15:0] DAT_I,
  output logic [15:0] DAT_O,
  output logic        ACK_O,
  output logic [7:0]  SEG_n_O,
  output logic [3:0]  AN_n_O
);

  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BL   = CW'(BLANK);

  logic [9:0]    r_dr [4];
  logic          r_ack;
  logic [15:0]   r_dat;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_dig;
  scan_t         r_st;
  logic [7:0]    r_seg;
  logic [3:0]    r_an;

  logic          w_acc;
  logic          w_wrap;
  logic [CW-1:0] w_cnt_nx;
  logic [1:0]    w_dig_nx;
  logic [9:0]    w_dr;
  logic [6:0]    w_glyph;
  logic [7:0]    w_pat;
  logic [3:0]    w_an;
  logic          w_unused;

  assign w_unused = &{1'b0, DAT_I[15:10]};

  // a new access is accepted only when ack is not already high
  assign w_acc = CYC_I & STB_I & ~r_ack;

  // bus side: single-cycle ack, lane-masked write, registered read
  always_ff @(posedge CLK_I or posedge RES_I) begin
    if (RES_I) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      for (int i = 0; i < 4; i++) r_dr[i] <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_acc ? {6'd0, r_dr[ADR_I]} : '0;
      if (w_acc & WE_I) begin
        if (SEL_I[0]) r_dr[ADR_I][7:0] <= DAT_I[7:0];
        if (SEL_I[1]) r_dr[ADR_I][9:8] <= DAT_I[9:8];
      end
    end
  end

  assign ACK_O = r_ack;
  assign DAT_O = r_dat;

  // pins are registered from next-cycle scan position
  assign w_wrap   = (r_cnt == LAST);
  assign w_cnt_nx = w_wrap ? '0 : r_cnt + 1'b1;
  assign w_dig_nx = w_wrap ? r_dig + 2'd1 : r_dig;
  assign w_dr     = r_dr[w_dig_nx];

  hex7seg u_hex (
    .i_nib (w_dr[3:0]),
    .o_seg (w_glyph)
  );

  assign w_pat = w_dr[HEX_B] ? {w_dr[7], w_glyph} : w_dr[7:0];

  // only the scanned digit's anode may be pulled low
  always_comb begin
    w_an           = 4'hF;
    w_an[w_dig_nx] = ~w_dr[EN_B];
  end

  // scan FSM: BLANK for the first BLANK counts, SHOW for the rest
  always_ff @(posedge CLK_I or posedge RES_I) begin
    if (RES_I) begin
      r_cnt <= '0;
      r_dig <= '0;
      r_st  <= S_BLANK;
      r_seg <= 8'hFF;
      r_an  <= 4'hF;
    end else begin
      r_cnt <= w_cnt_nx;
      r_dig <= w_dig_nx;
      unique case (r_st)
        S_BLANK: begin
          if (w_cnt_nx == BL) begin
            r_st  <= S_SHOW;
            r_seg <= ~w_pat;
            r_an  <= w_an;
          end else begin
            r_seg <= 8'hFF;
            r_an  <= 4'hF;
          end
        end
        S_SHOW: begin
          if (w_wrap) begin
            r_st  <= S_BLANK;
            r_seg <= 8'hFF;
            r_an  <= 4'hF;
          end else begin
            r_seg <= ~w_pat;
            r_an  <= w_an;
          end
        end
        default: begin
          r_st  <= S_BLANK;
          r_seg <= 8'hFF;
          r_an  <= 4'hF;
        end
      endcase
    end
  end

  assign SEG_n_O = r_seg;
  assign AN_n_O  = r_an;

endmodule

// File: tb/tb_led7_scan.sv
// tb_led7_scan: directed bench for led7_scan (DIV=8, BLANK=2)
// expected values queued on drive, popped on compare
module tb_led7_scan;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [1:0]  adr = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [1:0]  sel = '0;
  logic [15:0] dat_i = '0;
  logic [15:0] dat_o;
  logic        ack;
  logic [7:0]  seg;
  logic [3:0]  an;

  logic [15:0] q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_cyc = 0;
  int ack_cyc = 0;
  int m_cnt = 0;
  int m_dig = 0;
  logic [9:0] m_dr [4];

  always #5 clk = ~clk;

  led7_scan #(.DIV(8), .BLANK(2)) dut (
    .CLK_I   (clk),
    .RES_I   (res),
    .ADR_I   (adr),
    .WE_I    (we),
    .CYC_I   (cyc),
    .STB_I   (stb),
    .SEL_I   (sel),
    .DAT_I   (dat_i),
    .DAT_O   (dat_o),
    .ACK_O   (ack),
    .SEG_n_O (seg),
    .AN_n_O  (an)
  );

  always @(posedge clk) n_cyc <= n_cyc + 1;

  // reference scan position
  always @(posedge clk or posedge res) begin
    if (res) begin
      m_cnt <= 0;
      m_dig <= 0;
    end else if (m_cnt == 7) begin
      m_cnt <= 0;
      m_dig <= (m_dig + 1) % 4;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06;
      4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D;
      4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F;
      4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E;
      4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    e = q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic chk_pins(input string tag);
    logic [9:0] d;
    logic [7:0] es;
    logic [3:0] ea;
    d  = m_dr[m_dig];
    es = 8'hFF;
    ea = 4'hF;
    if (m_cnt >= 2) begin
      es = d[8] ? ~{d[7], glyph(d[3:0])} : ~d[7:0];
      ea[m_dig] = ~d[9];
    end
    push({8'h0, es});
    chk({tag, "_seg"}, {8'h0, seg});
    push({12'h0, ea});
    chk({tag, "_an"}, {12'h0, an});
  endtask

  task automatic wr(input int a, input logic [15:0] d,
                    input logic [1:0] s);
    adr = 2'(a); we = 1'b1; sel = s; dat_i = d;
    cyc = 1'b1; stb = 1'b1;
    tick;
    push(16'd1); chk("wr_ack", {15'd0, ack});
    ack_cyc = n_cyc;
    chk_pins("wr_n");
    if (s[0]) m_dr[a][7:0] = d[7:0];
    if (s[1]) m_dr[a][9:8] = d[9:8];
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick;
    push(16'd0); chk("wr_drop", {15'd0, ack});
    chk_pins("wr_n1");
  endtask

  task automatic rd(input int a, input logic [15:0] e);
    adr = 2'(a); we = 1'b0; sel = 2'b11;
    cyc = 1'b1; stb = 1'b1;
    tick;
    push(16'd1); chk("rd_ack", {15'd0, ack});
    push(e); chk("rd_data", dat_o);
    cyc = 1'b0; stb = 1'b0;
    tick;
    push(16'd0); chk("rd_drop", {15'd0, ack});
    push(16'd0); chk("rd_idle", dat_o);
  endtask

  task automatic wait_slot(input int d, input int c);
    int n;
    n = 0;
    while (!(m_dig == d && m_cnt == c) && n < 64) begin
      tick;
      n++;
    end
    push(16'd1);
    chk("wait_slot", {15'd0, (m_dig == d && m_cnt == c)});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    for (int i = 0; i < 4; i++) m_dr[i] = '0;

    // held reset
    repeat (2) @(posedge clk);
    #1;
    push(16'h00FF); chk("rst_seg", {8'h0, seg});
    push(16'h000F); chk("rst_an", {12'h0, an});
    push(16'h0000); chk("rst_ack", {15'd0, ack});
    push(16'h0000); chk("rst_dat", dat_o);
    #3 res = 1'b0;

    // first SHOW after release is digit 0 at cnt 2
    wr(0, 16'h023F, 2'b11);
    push(16'h000E); chk("first_show_an", {12'h0, an});
    for (int i = 0; i < 8; i++) begin
      tick;
      chk_pins("scan0");
    end

    // hex mode with dp
    wr(1, 16'h0385, 2'b11);
    wait_slot(1, 4);
    push(16'h000D); chk("hex_an", {12'h0, an});
    push(16'h0012); chk("hex_seg", {8'h0, seg});

    // byte lanes, back-to-back transfers
    wr(2, 16'h02FF, 2'b01);
    a0 = ack_cyc;
    wr(2, 16'h0200, 2'b10);
    push(16'd2); chk("b2b_gap", 16'(ack_cyc - a0));
    rd(2, 16'h02FF);

    // disabled digit and wrap
    wr(3, 16'h00FF, 2'b11);
    wait_slot(3, 0);
    for (int i = 0; i < 8; i++) begin
      chk_pins("dis");
      push(16'h000F); chk("dis_an", {12'h0, an});
      tick;
    end
    tick;
    tick;
    push(16'h000E); chk("wrap_an", {12'h0, an});

    // live update during SHOW, reserved bits dropped
    wait_slot(0, 3);
    wr(0, 16'hFE06, 2'b11);
    push(16'h00F9); chk("live_seg", {8'h0, seg});
    rd(0, 16'h0206);

    // strobe held six cycles
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 2'b11;
    for (int k = 0; k < 6; k++) begin
      adr = 2'(k % 4);
      dat_i = 16'h0300 | 16'(k);
      tick;
      push(16'((k % 2) == 0)); chk("held_ack", {15'd0, ack});
      chk_pins("held");
      if ((k % 2) == 0) m_dr[k % 4] = 10'h300 | 10'(k);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick;
    chk_pins("held_end");
    rd(0, 16'h0304);
    rd(1, 16'h0385);
    rd(2, 16'h0302);
    rd(3, 16'h00FF);

    // asynchronous reset mid-transfer, mid-SHOW
    wait_slot(0, 3);
    adr = 2'd0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    tick;
    push(16'd1); chk("pre_rst_ack", {15'd0, ack});
    push(16'h000E); chk("pre_rst_an", {12'h0, an});
    #2 res = 1'b1;
    #1;
    push(16'h00FF); chk("arst_seg", {8'h0, seg});
    push(16'h000F); chk("arst_an", {12'h0, an});
    push(16'h0000); chk("arst_ack", {15'd0, ack});
    push(16'h0000); chk("arst_dat", dat_o);
    for (int i = 0; i < 4; i++) m_dr[i] = '0;
    cyc = 1'b0; stb = 1'b0;
    #2 res = 1'b0;
    wr(0, 16'h0208, 2'b11);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk_pins("post_rst");
    end
    rd(1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led7_scan.md
# led7_scan

Wishbone B3 slave that owns the Nexys2 four-digit seven-segment display and replaces direct CPU bit-banging of segment and anode lines. It sits downstream of the CPU bus decoder, in the I/O page at 0x1000. It holds one 16-bit register per digit and multiplexes the digits in hardware with an inter-digit blanking gap. It drives the board's active-low segment and anode pins directly.

## Interface
Parameters:
- `DIV`, 50000: cycles per digit slot (1 kHz per digit at 50 MHz); legal range 4..2^20.
- `BLANK`, 500: cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK < DIV.

Ports:
- `CLK_I`, in, 1: system clock (50 MHz).
- `RES_I`, in, 1: asynchronous, active-high reset.
- `ADR_I`, in, 2: word address `cpu_adr[2:1]`, selecting digit 0..3.
- `WE_I`, in, 1: write enable.
- `CYC_I`, in, 1: bus cycle.
- `STB_I`, in, 1: strobe, already qualified by the page decode.
- `SEL_I`, in, 2: byte lanes; [0] = bits 7:0, [1] = bits 15:8.
- `DAT_I`, in, 16: write data.
- `DAT_O`, out, 16: read data.
- `ACK_O`, out, 1: transfer acknowledge.
- `SEG_n_O`, out, 8: segments a,b,c,d,e,f,g,dp on bits 0..7, active low.
- `AN_n_O`, out, 4: digit anodes 0..3, active low.

## Operation
Digit register layout (`DR0`..`DR3`):
- [7:0]: raw segment pattern, bit = 1 lights the segment.
- [8]: HEX mode. When set, segments a..g come from the hex decode of [3:0], and dp comes from [7].
- [9]: EN. When clear, the digit's anode stays off during its slot.
- [15:10]: read back as zero and ignored on write.

Bus behaviour:
- Every access (`CYC_I & STB_I`) is acknowledged with a single-cycle `ACK_O`: `ACK_O <= ~ACK_O & CYC_I & STB_I`.
- A write updates only the lanes enabled in `SEL_I`, on the edge where `ACK_O` is raised.
- Read data is `DR[ADR_I]`, registered and valid while `ACK_O` is high; `DAT_O` is 0 otherwise.
- Hex decode glyphs (gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.

Scan state machine (`BLANK`, `SHOW`):
- A slot counter `cnt` runs 0..DIV-1. The digit index `dig` is 2 bits and advances 3→0 on wrap.
- State `BLANK` covers `cnt` < BLANK: `AN_n_O` = 4'hF and `SEG_n_O` = 8'hFF.
- State `SHOW` covers the remaining DIV-BLANK cycles: `AN_n_O[dig]` = ~EN(dig), all other anodes high, `SEG_n_O` = ~pattern(dig).
- When `cnt` = DIV-1: `cnt` clears, `dig` increments, and the state returns to `BLANK`.

Reset:
- `DR0`..`DR3` = 0.
- `cnt` = 0, `dig` = 0, state `BLANK`.
- `ACK_O` = 0, `DAT_O` = 0, `SEG_n_O` = 8'hFF, `AN_n_O` = 4'hF.
- Asserting reset mid-scan or mid-transfer forces these values immediately. Scanning restarts with digit 0 in `BLANK` after reset is released.

## Timing
- Transfer timing: request sampled at edge N; `ACK_O` and register update at edge N; `ACK_O` drops at edge N+1 even if `STB_I` stays high.
- Back-to-back accesses therefore take 2 cycles each.
- `SEG_n_O` and `AN_n_O` are registered. A write to the currently shown digit is visible on the pins at edge N+1.
- Write and scan advance in the same cycle: the scan uses the old value that cycle and the new value from the next.
- No glitches on pin outputs; both pin buses are driven from flops.
- A `CYC_I` drop mid-transfer does not cancel a write already captured at edge N.

## Structure
- Shared package `led7_pkg`:
  - bit positions `HEX_B=8` and `EN_B=9`;
  - the segment glyph constants;
  - localparam width `$clog2(DIV)` for `cnt`.
- Sub-module `hex7seg`: purely combinational 4-bit to 7-bit decoder, instantiated once on the selected digit's nibble.
- The top level maps this block at `cpu_adr[15:12]==4'h1`, replacing the discrete LED flops.

## Test plan
Bench uses DIV=8 and BLANK=2.
1. Reset check: pulse `RES_I` asynchronously mid-cycle → outputs immediately `SEG_n_O`=FF, `AN_n_O`=F, `ACK_O`=0; after release, the first SHOW is digit 0 at cycles 2..7.
2. Hex mode: write `DR1`=0x0385 (EN, HEX, dp, nibble 5), SEL=11 → in digit 1's SHOW, `AN_n_O`=4'hD and `SEG_n_O`=~8'hED=8'h12.
3. Byte lanes: write 0x02FF with SEL=01 and then 0x0200 with SEL=10 to `DR2` → read returns 0x02FF; ACK lasts 1 cycle per transfer, and the second transfer acks 2 cycles after the first.
4. Disabled digit: write `DR3`=0x00FF (EN=0) → `AN_n_O` stays 4'hF during all of digit 3's slot; the sequence wraps back to digit 0 after cnt=7.
5. Live update: write `DR0` during digit 0's SHOW → pins change at edge N+1; reserved bits 15:10 written as 1 read back 0.
6. Held strobe: hold `STB_I` high for 6 cycles → `ACK_O` toggles 1,0,1,0,1,0 and exactly 3 writes occur.
